// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART block family (arbiter, Uart_TX, Uart_RX).
//   - arb_state_t : state encoding of the transmit arbiter FSM
//   - DATA_BITS_DEF : default byte width used across the UART blocks
//   - CLK_HZ / bit_period() : system clock and clocks-per-bit for a baud rate
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int CLK_HZ        = 100_000_000;

    // Clocks per UART bit, rounded to the nearest whole cycle.
    function automatic int bit_period(input int baud);
        return (CLK_HZ + baud / 2) / baud;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker.
//   req    : request vector, one bit per requester
//   last   : index granted most recently (search starts just above it)
//   winner : first requesting index found from last+1 upward, wrapping
//   any    : at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    winner,
    output logic             any
);

    int idx;

    // Walk the offsets from farthest to nearest so the nearest requester
    // above 'last' is the one left in 'winner'.
    always_comb begin
        winner = '0;
        any    = |req;
        idx    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[IW'(idx)]) begin
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one Uart_TX among N_REQ byte requesters with round-robin
// arbitration, optional packet locking, an idle gap after every frame and
// a sticky flag for a transmitter that never starts.
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-requester byte valid (held until req_ready)
//   req_data     : requester i at [i*DATA_BITS +: DATA_BITS]
//   req_last     : byte ends its packet
//   req_ready    : one-hot accept pulse
//   uart_data    : byte to Uart_TX data_in (held until next accept)
//   uart_start   : single-cycle tx_start pulse
//   uart_busy    : tx_busy from Uart_TX
//   grant_id     : current / last granted requester
//   active       : arbiter is busy with a frame (ACCEPT through GAP)
//   lock_active  : packet lock held by grant_id
//   err_nostart  : sticky, uart_busy never rose after a start
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_BITS     = DATA_BITS_DEF,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 4,
    parameter int LOCK_TIMEOUT  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]       uart_data,
    output logic                       uart_start,
    input  logic                       uart_busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active,
    output logic                       lock_active,
    output logic                       err_nostart
);

    localparam int IW = $clog2(N_REQ);
    localparam int LW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SW = $clog2(START_TIMEOUT) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

    arb_state_t           state, state_nxt;
    logic [IW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]        grant_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 lock_nxt;
    logic [LW-1:0]        lock_cnt, lock_cnt_nxt;
    logic [SW-1:0]        start_cnt, start_cnt_nxt;
    logic [GW-1:0]        gap_cnt, gap_cnt_nxt;
    logic                 err_nxt;
    logic [IW-1:0]        winner;
    logic                 any_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req_valid),
        .last   (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    // State and datapath registers; reset puts the pointer at N_REQ-1 so
    // requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= IW'(N_REQ - 1);
            grant_id    <= '0;
            uart_data   <= '0;
            lock_active <= 1'b0;
            lock_cnt    <= '0;
            start_cnt   <= '0;
            gap_cnt     <= '0;
            err_nostart <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            grant_id    <= grant_nxt;
            uart_data   <= data_nxt;
            lock_active <= lock_nxt;
            lock_cnt    <= lock_cnt_nxt;
            start_cnt   <= start_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            err_nostart <= err_nxt;
        end
    end

    // Next-state and output logic. The gap is entered both after a normal
    // frame and after a start timeout, so a dropped byte also gets the gap.
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_nxt     = grant_id;
        data_nxt      = uart_data;
        lock_nxt      = lock_active;
        lock_cnt_nxt  = lock_cnt;
        start_cnt_nxt = start_cnt;
        gap_cnt_nxt   = gap_cnt;
        err_nxt       = err_nostart;
        req_ready     = '0;
        uart_start    = 1'b0;
        active        = (state != IDLE);

        case (state)
            IDLE: begin
                if (lock_active) begin
                    if (req_valid[grant_id]) begin
                        state_nxt = ACCEPT;
                    end else if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
                        lock_nxt     = 1'b0;
                        lock_cnt_nxt = '0;
                    end else begin
                        lock_cnt_nxt = lock_cnt + 1'b1;
                    end
                end else if (any_req) begin
                    grant_nxt = winner;
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                req_ready[grant_id] = 1'b1;
                data_nxt     = req_data[int'(grant_id) * DATA_BITS +: DATA_BITS];
                rr_ptr_nxt   = grant_id;
                lock_nxt     = ~req_last[grant_id];
                lock_cnt_nxt = '0;
                state_nxt    = START;
            end
            START: begin
                uart_start    = 1'b1;
                start_cnt_nxt = '0;
                state_nxt     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (start_cnt == SW'(START_TIMEOUT - 1)) begin
                    err_nxt = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_cnt_nxt = GW'(GAP_CYCLES);
                        state_nxt   = GAP;
                    end
                end else begin
                    start_cnt_nxt = start_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_cnt_nxt = GW'(GAP_CYCLES);
                        state_nxt   = GAP;
                    end
                end
            end
            GAP: begin
                // GAP lasts exactly gap_cnt cycles; the last one is at count 1.
                if (gap_cnt == GW'(1) || gap_cnt == '0) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. A small behavioural transmitter
// raises uart_busy for FRAME cycles after each start. Per-requester byte
// queues feed req_valid/req_data; every uart_start is recorded and compared
// against the expected grant order pushed by each scenario task.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DB    = 8;
    localparam int GAPC  = 4;
    localparam int STO   = 4;
    localparam int LTO   = 32;
    localparam int FRAME = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DB-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [DB-1:0]     uart_data;
    logic              uart_start;
    logic              uart_busy;
    logic [1:0]        grant_id;
    logic              active;
    logic              lock_active;
    logic              err_nostart;

    logic              stuck;
    int                tx_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0]  pend [N][$];
    logic [9:0]  exp_q [$];
    logic [9:0]  obs_q [$];
    logic [N-1:0] prev_valid, prev_ready;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ         (N),
        .DATA_BITS     (DB),
        .GAP_CYCLES    (GAPC),
        .START_TIMEOUT (STO),
        .LOCK_TIMEOUT  (LTO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .uart_data   (uart_data),
        .uart_start  (uart_start),
        .uart_busy   (uart_busy),
        .grant_id    (grant_id),
        .active      (active),
        .lock_active (lock_active),
        .err_nostart (err_nostart)
    );

    // Behavioural transmitter: busy rises the cycle after an accepted start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_busy <= 1'b0;
            tx_cnt    <= 0;
        end else if (uart_busy) begin
            if (tx_cnt == FRAME - 1) uart_busy <= 1'b0;
            else tx_cnt <= tx_cnt + 1;
        end else if (uart_start && !stuck) begin
            uart_busy <= 1'b1;
            tx_cnt    <= 0;
        end
    end

    // Record every start and watch for a valid dropped before its ready.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = '0;
            prev_ready = '0;
        end else begin
            if (uart_start) obs_q.push_back({grant_id, uart_data});
            if ((prev_valid & ~prev_ready & ~req_valid) != '0) begin
                tests_failed++;
                $display("[TB] FAIL protocol_valid_drop valid=%b prev_valid=%b prev_ready=%b",
                         req_valid, prev_valid, prev_ready);
            end
            prev_valid = req_valid;
            prev_ready = req_ready;
        end
    end

    // Requester driver: retire the head byte after its accept has been
    // clocked, then present the next queued byte.
    initial begin
        logic [N-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!rst && acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
                if (pend[i].size() > 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*DB +: DB] = pend[i][0][7:0];
                    req_last[i]          = pend[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pend[i].delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic queue_byte(input int id, input logic [7:0] data, input logic last);
        pend[id].push_back({last, data});
    endtask

    task automatic wait_obs(input int n, input int budget, output bit timed_out);
        int c = 0;
        while (obs_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        timed_out = (obs_q.size() < n);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (req_ready !== '0) begin tests_failed++; $display("[TB] FAIL reset_req_ready got %b want 0", req_ready); end
        tests_run++;
        if (uart_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_uart_start got %b want 0", uart_start); end
        tests_run++;
        if (uart_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_uart_data got %h want 00", uart_data); end
        tests_run++;
        if ({grant_id, active, lock_active, err_nostart} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status got grant=%0d active=%b lock=%b err=%b want all 0",
                     grant_id, active, lock_active, err_nostart);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit to;
        int c;
        logic [9:0] e, o;
        queue_byte(2, 8'hA5, 1'b1);
        exp_q.push_back({2'd2, 8'hA5});
        c = 0;
        do begin @(negedge clk); c++; end while (!req_valid[2] && c < 20);
        tests_run++;
        if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_ready_early got %b want 0000", req_ready); end
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL single_ready got %b want 0100", req_ready); end
        @(negedge clk);
        tests_run++;
        if (uart_start !== 1'b1 || req_ready !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL single_start got start=%b ready=%b want 1/0000", uart_start, req_ready);
        end
        c = 0;
        while (!uart_busy && c < 20) begin @(negedge clk); c++; end
        while (uart_busy && c < 200) begin @(negedge clk); c++; end
        repeat (GAPC) @(negedge clk);
        tests_run++;
        if (active !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_gap_active got %b want 1", active); end
        @(negedge clk);
        tests_run++;
        if (active !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_gap_end got %b want 0", active); end
        wait_obs(1, 50, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL single_wait got %0d starts want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("[TB] FAIL single_byte got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_round_robin();
        bit to;
        logic [9:0] e, o;
        apply_reset();
        queue_byte(0, 8'h11, 1'b1); queue_byte(1, 8'h22, 1'b1);
        queue_byte(2, 8'h33, 1'b1); queue_byte(3, 8'h44, 1'b1);
        exp_q.push_back({2'd0, 8'h11}); exp_q.push_back({2'd1, 8'h22});
        exp_q.push_back({2'd2, 8'h33}); exp_q.push_back({2'd3, 8'h44});
        wait_obs(4, 400, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL rr_wait got %0d starts want 4", obs_q.size()); end
        wait_obs(4, 0, to);
        repeat (60) @(negedge clk);
        queue_byte(2, 8'h77, 1'b1); queue_byte(0, 8'h55, 1'b1);
        exp_q.push_back({2'd0, 8'h55}); exp_q.push_back({2'd2, 8'h77});
        wait_obs(6, 400, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL rr_wait2 got %0d starts want 6", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("[TB] FAIL rr_order got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        tests_run++;
        if (lock_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_lock got %b want 0", lock_active); end
    endtask

    task automatic test_packet_lock();
        bit to;
        int c;
        logic [9:0] e, o;
        apply_reset();
        queue_byte(1, 8'hC0, 1'b0);
        c = 0;
        while (pend[1].size() > 0 && c < 50) begin @(negedge clk); c++; end
        queue_byte(1, 8'hC1, 1'b0); queue_byte(1, 8'hC2, 1'b1);
        queue_byte(0, 8'h0A, 1'b1); queue_byte(3, 8'h3A, 1'b1);
        exp_q.push_back({2'd1, 8'hC0}); exp_q.push_back({2'd1, 8'hC1});
        exp_q.push_back({2'd1, 8'hC2}); exp_q.push_back({2'd3, 8'h3A});
        exp_q.push_back({2'd0, 8'h0A});
        wait_obs(5, 600, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL lock_wait got %0d starts want 5", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("[TB] FAIL lock_order got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_lock_timeout();
        bit to;
        int c, idle_locked;
        logic [9:0] e, o;
        apply_reset();
        queue_byte(1, 8'hD0, 1'b0);
        exp_q.push_back({2'd1, 8'hD0}); exp_q.push_back({2'd0, 8'h0B});
        c = 0;
        while (pend[1].size() > 0 && c < 50) begin @(negedge clk); c++; end
        queue_byte(0, 8'h0B, 1'b1);
        idle_locked = 0;
        c = 0;
        @(negedge clk);
        while (lock_active && c < 4 * LTO + 200) begin
            if (!active) idle_locked++;
            @(negedge clk);
            c++;
        end
        tests_run++;
        if (idle_locked != LTO) begin tests_failed++; $display("[TB] FAIL lock_timeout_cycles got %0d want %0d", idle_locked, LTO); end
        tests_run++;
        if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL lock_release_ready got %b want 0000", req_ready); end
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL lock_release_grant got %b want 0001", req_ready); end
        wait_obs(2, 200, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL lockto_wait got %0d starts want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("[TB] FAIL lockto_order got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_nostart();
        bit to;
        int c;
        logic [9:0] e, o;
        apply_reset();
        stuck = 1'b1;
        queue_byte(2, 8'hE1, 1'b1);
        exp_q.push_back({2'd2, 8'hE1}); exp_q.push_back({2'd3, 8'hE3});
        c = 0;
        do begin @(negedge clk); c++; end while (!uart_start && c < 50);
        repeat (STO) @(negedge clk);
        tests_run++;
        if (err_nostart !== 1'b0) begin tests_failed++; $display("[TB] FAIL nostart_early got %b want 0", err_nostart); end
        @(negedge clk);
        tests_run++;
        if (err_nostart !== 1'b1) begin tests_failed++; $display("[TB] FAIL nostart_set got %b want 1", err_nostart); end
        stuck = 1'b0;
        queue_byte(3, 8'hE3, 1'b1);
        wait_obs(2, 300, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL nostart_wait got %0d starts want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("[TB] FAIL nostart_order got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (40) @(negedge clk);
        tests_run++;
        if (err_nostart !== 1'b1) begin tests_failed++; $display("[TB] FAIL nostart_sticky got %b want 1", err_nostart); end
        apply_reset();
        @(negedge clk);
        tests_run++;
        if (err_nostart !== 1'b0) begin tests_failed++; $display("[TB] FAIL nostart_clear got %b want 0", err_nostart); end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int c;
        logic [9:0] e, o;
        apply_reset();
        queue_byte(0, 8'hBC, 1'b0);
        exp_q.push_back({2'd0, 8'hBC}); exp_q.push_back({2'd1, 8'h5A});
        c = 0;
        while (!uart_busy && c < 50) begin @(negedge clk); c++; end
        repeat (10) @(negedge clk);
        tests_run++;
        if (lock_active !== 1'b1 || active !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midframe_pre got lock=%b active=%b want 1/1", lock_active, active);
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) pend[i].delete();
        #1;
        tests_run++;
        if ({req_ready, uart_data, uart_start, grant_id, active, lock_active, err_nostart} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midframe_outputs got ready=%b data=%h start=%b grant=%0d active=%b lock=%b err=%b want all 0",
                     req_ready, uart_data, uart_start, grant_id, active, lock_active, err_nostart);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        queue_byte(1, 8'h5A, 1'b1);
        wait_obs(2, 200, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL midframe_wait got %0d starts want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("[TB] FAIL midframe_order got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        c = 0;
        while (active && c < 100) begin @(negedge clk); c++; end
        tests_run++;
        if (lock_active !== 1'b0 || active !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midframe_after got lock=%b active=%b want 0/0", lock_active, active);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_lock_timeout();
        test_nostart();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one Uart_TX transmitter among N byte requesters using round-robin arbitration and optional multi-byte packet locking.
- Sits between client logic (command responders, status reporters) and the Uart_TX instance. Drives its data_in/tx_start and watches tx_busy.
- Sequences one frame at a time, enforces a programmable inter-frame idle gap, and flags a transmitter that fails to start.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_BITS, 8, byte width; must match Uart_TX DATA_BITS
- GAP_CYCLES, 16, idle clk cycles inserted after tx_busy falls (0 = no gap)
- START_TIMEOUT, 4, cycles after uart_start within which uart_busy must rise
- LOCK_TIMEOUT, 1024, cycles a locked requester may stay idle before the lock is dropped

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester byte valid; must be held until the matching req_ready
- req_data  in  N_REQ*DATA_BITS  requester i occupies bits [i*DATA_BITS +: DATA_BITS]
- req_last  in  N_REQ  1 = this byte ends its packet; sampled with the byte
- req_ready  out  N_REQ  one-hot single-cycle accept pulse
- uart_data  out  DATA_BITS  to Uart_TX data_in
- uart_start  out  1  to Uart_TX tx_start; single-cycle pulse
- uart_busy  in  1  from Uart_TX tx_busy
- grant_id  out  clog2(N_REQ)  index of the current/last granted requester
- active  out  1  high from ACCEPT through end of GAP
- lock_active  out  1  packet lock held
- err_nostart  out  1  sticky; set when uart_busy fails to rise; cleared only by rst

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, lock cleared, rr pointer = N_REQ-1 (requester 0 wins first), all counters 0.
- IDLE:
  - If lock_active, only grant_id is eligible. If req_valid[grant_id]=1, go ACCEPT. Otherwise lock_cnt++. When lock_cnt reaches LOCK_TIMEOUT-1, clear the lock, reset lock_cnt, and stay IDLE. Arbitration reopens the next cycle.
  - If unlocked and any req_valid, register the winner: first valid index searching from rr_ptr+1 upward, wrapping modulo N_REQ. Set grant_id to the winner and go ACCEPT.
- ACCEPT (1 cycle):
  - req_ready[grant_id]=1.
  - Latch req_data slice into uart_data.
  - rr_ptr <= grant_id.
  - lock_active <= ~req_last[grant_id]; lock_cnt <= 0.
  - Next state START.
- START (1 cycle): uart_start=1, start_cnt <= 0, next WAIT_BUSY.
- WAIT_BUSY:
  - uart_busy=1 → go WAIT_DONE.
  - Else start_cnt++. When start_cnt reaches START_TIMEOUT-1, set err_nostart and go GAP. The byte is dropped and not retried.
- WAIT_DONE: uart_busy=0 → load gap_cnt=GAP_CYCLES and go GAP. If GAP_CYCLES=0, go IDLE directly.
- GAP: decrement gap_cnt; at 0 go IDLE. req_ready stays low throughout.
- Latency:
  - Valid in IDLE → req_ready at cycle +1 → uart_start at +2.
  - Byte-to-byte spacing = Uart_TX frame time + GAP_CYCLES + 3 cycles.
- uart_data holds its value from ACCEPT until the next ACCEPT, so it is stable while Uart_TX samples data_in.
- Simultaneous events:
  - A valid arriving in the same cycle the rr pointer updates is seen by the next IDLE evaluation.
  - req_valid dropping before ready is a protocol violation; the result is undefined, and the bench asserts it never happens.
- uart_busy high while in IDLE (external stall): the arbiter does not wait for it; the Uart_TX idle guard ignores tx_start. WAIT_BUSY then times out and sets err_nostart.
- rst mid-frame: aborts the frame immediately. The in-flight byte is lost; the lock and err_nostart are cleared.
- Packet lock: bytes from other requesters are never interleaved inside a packet, unless the lock timeout fires.
- Width rules: grant_id, rr_ptr and the winner search use clog2(N_REQ) bits with explicit wrap. Counters are sized clog2(max param)+1 and compare with ==, not underflow.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE, ACCEPT, START, WAIT_BUSY, WAIT_DONE, GAP)
  - DATA_BITS default
  - CLK_HZ = 100_000_000 and the BIT_PERIOD formula, also reused by Uart_TX/Uart_RX
- One sub-module, rr_pick: combinational round-robin priority picker (req vector, last pointer → winner index, any). Everything else stays in one FSM block.

Test Plan:
- Single requester: req 2 sends 8'hA5 with last=1 → req_ready[2] one pulse; uart_start 1 cycle later; tx_out bits match 0xA5 LSB-first; Uart_RX loopback data_out=0xA5; active falls GAP_CYCLES after tx_busy falls.
- Round-robin: all 4 requesters hold a byte (0x11, 0x22, 0x33, 0x44), last=1, from reset → grant order 0,1,2,3; then 0 and 2 re-request → order 0,2.
- Packet lock: req 1 sends 0xC0 (last=0), 0xC1 (last=0), 0xC2 (last=1) while req 0 and 3 stay valid → three req 1 bytes consecutively, then req 3, then req 0 (rr pointer continues from 1).
- Lock timeout: req 1 sends 0xD0 with last=0, then deasserts; req 0 valid → lock_active drops after LOCK_TIMEOUT idle cycles; req 0 granted on the following cycle.
- No-start fault: tie uart_busy=0 → err_nostart set START_TIMEOUT cycles after uart_start; next requester still served; err_nostart stays 1 until rst.
- Reset mid-frame: assert rst during data bit 4 of 0xBC → all outputs 0 immediately, lock cleared; after release, a new 0x5A transmits cleanly and loopback receives 0x5A.
